// File: rtl/adc_trig_capture_pkg.sv
// adc_trig_capture_pkg
//   Shared definitions for the triggered ADC capture buffer:
//   - cap_state_t  : capture state machine encoding
//   - CHAN_W       : width of one deserialized channel word
//   - sample_width : full sample word width for a given channel count
package adc_trig_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_DONE
  } cap_state_t;

  localparam int CHAN_W = 16;

  function automatic int sample_width(input int chnls);
    return chnls * CHAN_W;
  endfunction

endpackage

// File: rtl/adc_cap_ram.sv
// adc_cap_ram
//   Simple dual-port capture memory: one synchronous write port and one
//   registered read port, shaped to infer block RAM.
// Ports:
//   clk      in   clock for both ports
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data updates only when set
//   rd_addr  in   read address
//   rd_data  out  read data, one cycle after rd_en
module adc_cap_ram
  import adc_trig_capture_pkg::*;
#(
  parameter int WIDTH  = sample_width(8),
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // No reset on the output register so it maps onto the RAM primitive.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/adc_trig_capture.sv
// adc_trig_capture
//   Triggered multi-channel capture buffer. After Arm it records a rolling
//   pre-trigger history, detects a level crossing (or a forced trigger) on a
//   selected channel, fills the rest of the ring with post-trigger samples,
//   then freezes the record for random-access readout by logical address.
// Ports:
//   AdcFrmClk     in   frame clock, all logic runs on it
//   SysRst        in   asynchronous active-high reset
//   AdcDataValid  in   per-channel valid; a sample is accepted when all set
//   AdcDataBus    in   channel words, Ch0 in bits [15:0]
//   Arm           in   pulse: start / restart a capture
//   ForceTrig     in   pulse: unconditional trigger while waiting
//   TrigCh        in   channel compared for the level trigger
//   TrigLevel     in   unsigned trigger threshold
//   TrigRising    in   1 = rising crossing, 0 = falling crossing
//   RdEn          in   read strobe
//   RdAddr        in   logical read address, 0 = oldest sample
//   RdData        out  read data (one cycle latency)
//   RdVld         out  read data valid
//   Busy          out  capture in progress
//   Done          out  record complete and frozen
//   TrigAddr      out  physical buffer address of the trigger sample
module adc_trig_capture
  import adc_trig_capture_pkg::*;
#(
  parameter int C_AdcChnls  = 8,
  parameter int C_DepthLog2 = 10,
  parameter int C_PreTrig   = 256
) (
  input  logic                                 AdcFrmClk,
  input  logic                                 SysRst,
  input  logic [C_AdcChnls-1:0]                AdcDataValid,
  input  logic [sample_width(C_AdcChnls)-1:0]  AdcDataBus,
  input  logic                                 Arm,
  input  logic                                 ForceTrig,
  input  logic [2:0]                           TrigCh,
  input  logic [CHAN_W-1:0]                    TrigLevel,
  input  logic                                 TrigRising,
  input  logic                                 RdEn,
  input  logic [C_DepthLog2-1:0]               RdAddr,
  output logic [sample_width(C_AdcChnls)-1:0]  RdData,
  output logic                                 RdVld,
  output logic                                 Busy,
  output logic                                 Done,
  output logic [C_DepthLog2-1:0]               TrigAddr
);

  localparam int SAMPLE_W = sample_width(C_AdcChnls);
  localparam int DEPTH    = 2 ** C_DepthLog2;
  localparam int POST_N   = DEPTH - C_PreTrig - 1;
  localparam int SEL_N    = 8;  // channels addressable by the 3-bit TrigCh

  localparam logic [C_DepthLog2-1:0] PRE_LAST  = C_DepthLog2'(C_PreTrig - 1);
  localparam logic [C_DepthLog2-1:0] POST_LAST = C_DepthLog2'(POST_N - 1);
  localparam logic [C_DepthLog2-1:0] PRE_OFS   = C_DepthLog2'(C_PreTrig);

  cap_state_t state_reg, state_next;

  logic [C_DepthLog2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [C_DepthLog2-1:0] cnt_reg, cnt_next;
  logic [C_DepthLog2-1:0] trig_addr_reg, trig_addr_next;
  logic [CHAN_W-1:0]      prev_reg, prev_next;
  logic                   force_pend_reg, force_pend_next;
  logic                   rd_vld_reg;

  logic                   accept;
  logic                   wr_en;
  logic                   level_en;
  logic                   rise_hit;
  logic                   fall_hit;
  logic                   level_hit;
  logic                   trig_fire;
  logic [CHAN_W-1:0]      cur_word;
  logic [C_DepthLog2-1:0] rd_phys;
  logic [SAMPLE_W-1:0]    ram_rd_data;

  // Channel selector table padded to the full TrigCh range so the mux index
  // can never run off the end; padding entries read as zero.
  logic [CHAN_W-1:0] chan_word [SEL_N];

  generate
    for (genvar gi = 0; gi < SEL_N; gi++) begin : g_chan
      if (gi < C_AdcChnls) begin : g_used
        assign chan_word[gi] = AdcDataBus[gi*CHAN_W +: CHAN_W];
      end else begin : g_unused
        assign chan_word[gi] = '0;
      end
    end
  endgenerate

  assign accept   = &AdcDataValid;
  assign cur_word = chan_word[TrigCh];
  assign level_en = (int'(TrigCh) < C_AdcChnls);

  // Crossing detection is combinational against the registered previous
  // accepted sample, so the sample that crosses is the one tagged.
  assign rise_hit  = (prev_reg < TrigLevel) && (cur_word >= TrigLevel);
  assign fall_hit  = (prev_reg >= TrigLevel) && (cur_word < TrigLevel);
  assign level_hit = level_en && (TrigRising ? rise_hit : fall_hit);
  assign trig_fire = accept && (level_hit || ForceTrig || force_pend_reg);

  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    cnt_next        = cnt_reg;
    trig_addr_next  = trig_addr_reg;
    prev_next       = prev_reg;
    force_pend_next = force_pend_reg;
    wr_en           = 1'b0;

    if (accept) begin
      prev_next = cur_word;
    end

    if (Arm) begin
      // Restart wins over any trigger or completion in the same cycle.
      state_next      = ST_PRE;
      wr_ptr_next     = '0;
      cnt_next        = '0;
      force_pend_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
        end

        ST_PRE: begin
          if (accept) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (cnt_reg == PRE_LAST) begin
              cnt_next   = '0;
              state_next = ST_WAIT;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end

        ST_WAIT: begin
          // A force without a sample is held until the next accepted one.
          if (ForceTrig && !accept) begin
            force_pend_next = 1'b1;
          end
          if (accept) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (trig_fire) begin
              trig_addr_next  = wr_ptr_reg;
              cnt_next        = '0;
              force_pend_next = 1'b0;
              state_next      = (POST_N == 0) ? ST_DONE : ST_POST;
            end
          end
        end

        ST_POST: begin
          if (accept) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (cnt_reg == POST_LAST) begin
              state_next = ST_DONE;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge AdcFrmClk or posedge SysRst) begin
    if (SysRst) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      cnt_reg        <= '0;
      trig_addr_reg  <= '0;
      prev_reg       <= '0;
      force_pend_reg <= 1'b0;
      rd_vld_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      cnt_reg        <= cnt_next;
      trig_addr_reg  <= trig_addr_next;
      prev_reg       <= prev_next;
      force_pend_reg <= force_pend_next;
      rd_vld_reg     <= RdEn;
    end
  end

  // Logical 0 is the oldest pre-trigger sample; the subtraction wraps
  // naturally in the pointer width.
  assign rd_phys = trig_addr_reg - PRE_OFS + RdAddr;

  adc_cap_ram #(
    .WIDTH  (SAMPLE_W),
    .ADDR_W (C_DepthLog2)
  ) u_ram (
    .clk     (AdcFrmClk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (AdcDataBus),
    .rd_en   (RdEn),
    .rd_addr (rd_phys),
    .rd_data (ram_rd_data)
  );

  // The RAM output register carries no reset, so the port is gated by the
  // registered valid to present zero after reset.
  assign RdData   = rd_vld_reg ? ram_rd_data : '0;
  assign RdVld    = rd_vld_reg;
  assign Busy     = (state_reg == ST_PRE) || (state_reg == ST_WAIT) ||
                    (state_reg == ST_POST);
  assign Done     = (state_reg == ST_DONE);
  assign TrigAddr = trig_addr_reg;

endmodule

// File: doc/adc_trig_capture.md
# adc_trig_capture

Triggered multi-channel capture buffer that sits directly downstream of the LVDS ADC deserializer, in the `AdcFrmClk` domain. It takes the eight deserialized 16-bit channel words and their per-channel valid flags. After an arm it keeps a rolling pre-trigger history, detects a level crossing on a selected channel, and fills the rest of an on-chip buffer with post-trigger samples. It then presents the frozen record through a random-access read port for the PS or the ILA.

## Interface
- `C_AdcChnls`, 8, number of channels; sample word width is `C_AdcChnls*16`.
- `C_DepthLog2`, 10, buffer depth = 2^`C_DepthLog2` samples.
- `C_PreTrig`, 256, pre-trigger samples kept; legal range 1 to depth-1.

Ports (reset is asynchronous and active-high; one clock):
- `AdcFrmClk`  in  1  frame clock; all logic runs on it.
- `SysRst`  in  1  asynchronous, active-high reset.
- `AdcDataValid`  in  `C_AdcChnls`  per-channel valid from the deserializer.
- `AdcDataBus`  in  `C_AdcChnls*16`  channel words; Ch0 occupies bits [15:0].
- `Arm`  in  1  single-cycle pulse that starts or restarts a capture.
- `ForceTrig`  in  1  pulse that triggers unconditionally while in WAIT.
- `TrigCh`  in  3  channel index compared for the trigger.
- `TrigLevel`  in  16  unsigned threshold.
- `TrigRising`  in  1  1 = rising crossing, 0 = falling crossing.
- `RdEn`  in  1  read strobe.
- `RdAddr`  in  `C_DepthLog2`  logical address; 0 = oldest sample.
- `RdData`  out  `C_AdcChnls*16`  read data.
- `RdVld`  out  1  read data valid.
- `Busy`  out  1  high while in PRE, WAIT or POST.
- `Done`  out  1  record complete and frozen.
- `TrigAddr`  out  `C_DepthLog2`  physical buffer address of the trigger sample.

## Operation
- A sample is accepted only in a cycle where `&AdcDataValid` = 1. Non-accepted cycles change nothing.
- States:
  - IDLE: the block waits for `Arm`.
  - PRE: writes accepted samples and counts them; after `C_PreTrig` accepted samples it moves to WAIT.
  - WAIT: keeps writing into the ring and evaluates the trigger on each accepted sample.
  - POST: writes accepted samples and counts them; after depth-`C_PreTrig`-1 samples past the trigger it moves to DONE.
  - DONE: writes stop and `Done` is high.
- Transitions:
  - `Arm` in any state clears the counters, clears `Done`, resets the write pointer to 0, and enters PRE.
  - `Arm` has priority over any simultaneous trigger or state-completion event.
- Trigger condition, evaluated on the sample of channel `TrigCh` against the previous accepted sample of that channel:
  - Rising: previous < `TrigLevel` and current >= `TrigLevel`.
  - Falling: previous >= `TrigLevel` and current < `TrigLevel`.
  - The first sample written in WAIT is always eligible, because PRE supplies its predecessor.
- `ForceTrig` in WAIT triggers on the current accepted sample; if no sample is accepted that cycle, it waits for the next accepted sample.
- The trigger sample is written at the physical address the write pointer holds that cycle, and that address is latched into `TrigAddr`.
- The write pointer wraps modulo the depth. Because PRE fills exactly `C_PreTrig` samples, the pre-history is always complete.
- Logical-to-physical read mapping: physical = (`TrigAddr` - `C_PreTrig` + `RdAddr`) mod depth.
  - The trigger sample therefore reads back at logical `C_PreTrig`.
  - Logical depth-1 is the last post-trigger sample.
- Reads are honoured in any state; data is specified only while `Done` = 1.
- `TrigCh` >= `C_AdcChnls` disables level triggering; only `ForceTrig` can trigger.
- Reset, including mid-capture: state goes to IDLE; `Busy` = 0, `Done` = 0, `TrigAddr` = 0, `RdVld` = 0, `RdData` = 0. RAM contents are not cleared.

## Timing
- A write occurs in the same cycle the sample is accepted.
- The trigger decision is combinational on the registered previous sample and the current input, so there are no lost samples.
- `Done` rises on the cycle after the final post-trigger write; `Busy` falls in that same cycle.
- Read latency is one cycle: `RdVld` and `RdData` are registered, and `RdVld` is `RdEn` delayed by one cycle.
- `Busy` rises on the cycle after `Arm`.

## Structure
- Shared package holds:
  - the state enumeration (IDLE, PRE, WAIT, POST, DONE);
  - the channel word width constant (16);
  - a function that computes the sample word width from `C_AdcChnls`.
- Sub-module `adc_cap_ram`: simple dual-port RAM with one write port and one registered read port, depth 2^`C_DepthLog2`, inferred as block RAM.
- Everything else (FSM, counters, trigger compare, address mapping) lives in the top of this block.

## Test plan
All scenarios use `C_DepthLog2`=4, `C_PreTrig`=4, and a ramp on Ch0 of n = 0,1,2,… with all valids high.
- Rising trigger: `TrigLevel`=100, `TrigRising`=1, `Arm` -> trigger at n=100; `Done` one cycle after n=111 is written; reading logical 0..15 returns Ch0 = 96..111, with logical 4 = 100.
- Valid gaps: clear `AdcDataValid[3]` on every other cycle -> record content identical to the previous scenario, and the latency to `Done` doubles.
- Falling trigger: Ch0 = 200 down to 0, `TrigLevel`=50, `TrigRising`=0 -> trigger on the sample with value 49; logical 4 = 49.
- Force trigger: `TrigCh`=7 with no crossing, `ForceTrig` pulsed at n=40 -> logical 4 = 40; wrap of `TrigAddr` checked against the mapping.
- Re-arm and reset: `Arm` during POST -> restarts in PRE and `Done` stays low; `SysRst` pulsed during WAIT -> `Busy`=0, `Done`=0, `TrigAddr`=0 immediately.
- Pre-history across wrap: trigger at n=1000 -> physical wrap exercised, logical 0..15 = 996..1011.
